// File: rtl/rob_retire.sv
// rob_retire: reorder buffer with in-order retirement toward the architectural
// map table.
//   - circular buffer of C_ROB_ENTRY_NUM entries; head/tail pointers carry one wrap bit
//   - up to C_DP_NUM dispatches, C_CDB_NUM completions and C_RT_NUM retirements per cycle
//   - a retiring mispredicted entry raises rollback_o and flushes the whole buffer
// Optional feature: define ROB_COMPLETE_BYPASS_EN to let a completion broadcast
// in cycle N make its entry retire-eligible in that same cycle. Without it, a
// completion becomes retire-eligible in cycle N+1 at the earliest.

`ifndef RT_NUM
`define RT_NUM 2
`endif

`ifndef TAG_IDX_WIDTH
`define TAG_IDX_WIDTH 6
`endif

package rob_retire_pkg;
  // One architectural map table write produced by a retiring entry
  typedef struct packed {
    logic                      wr_en;
    logic [4:0]                arch_reg;
    logic [`TAG_IDX_WIDTH-1:0] phy_reg;
  } rob_amt_t;
endpackage

module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int C_DP_NUM        = 2,
  parameter int C_RT_NUM        = `RT_NUM,
  parameter int C_CDB_NUM       = 2,
  parameter int C_ROB_ENTRY_NUM = 32,
  parameter int C_TAG_IDX_WIDTH = `TAG_IDX_WIDTH,
  localparam int C_IDX_W        = $clog2(C_ROB_ENTRY_NUM),
  localparam int C_PTR_W        = C_IDX_W + 1,
  localparam int C_AVAIL_W      = $clog2(C_DP_NUM + 1),
  localparam int C_RTCNT_W      = $clog2(C_RT_NUM + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  // Dispatch: dp_en_i[k] is a request; slot k is accepted in this cycle
  // exactly when dp_en_i[k]=1 and k < rob_avail_o. There is no stall: an
  // unaccepted slot is simply not written and must be re-presented later.
  input  logic [C_DP_NUM-1:0]                       dp_en_i,
  input  logic [C_DP_NUM-1:0]                       dp_wr_en_i,
  input  logic [C_DP_NUM-1:0][4:0]                  dp_arch_reg_i,
  input  logic [C_DP_NUM-1:0][C_TAG_IDX_WIDTH-1:0]  dp_phy_reg_i,
  output logic [C_AVAIL_W-1:0]                      rob_avail_o,
  output logic [C_DP_NUM-1:0][C_IDX_W-1:0]          dp_rob_idx_o,
  // Completion broadcasts
  input  logic [C_CDB_NUM-1:0]                      cdb_valid_i,
  input  logic [C_CDB_NUM-1:0][C_IDX_W-1:0]         cdb_rob_idx_i,
  input  logic [C_CDB_NUM-1:0]                      cdb_mispred_i,
  // Retirement
  output rob_amt_t [C_RT_NUM-1:0]                   rob_amt_o,
  output logic                                      rollback_o
);

  // Pointers: low C_IDX_W bits index the entry array, the top bit is the wrap bit
  logic [C_PTR_W-1:0] r_head;
  logic [C_PTR_W-1:0] r_tail;

  // Per-entry status
  logic [C_ROB_ENTRY_NUM-1:0] r_valid;
  logic [C_ROB_ENTRY_NUM-1:0] r_complete;
  logic [C_ROB_ENTRY_NUM-1:0] r_mispred;

  // Per-entry payload
  logic [C_ROB_ENTRY_NUM-1:0] r_wr_en;
  logic [4:0]                 r_arch_reg [C_ROB_ENTRY_NUM];
  logic [C_TAG_IDX_WIDTH-1:0] r_phy_reg  [C_ROB_ENTRY_NUM];

  // Occupancy / dispatch
  logic [C_PTR_W-1:0]         w_count;
  logic [C_PTR_W-1:0]         w_free;
  logic [C_AVAIL_W-1:0]       w_avail;
  logic [C_DP_NUM-1:0]        w_dp_acc;
  logic [C_AVAIL_W-1:0]       w_dp_cnt;

  // Retirement
  logic [C_RT_NUM-1:0]              w_rt_fire;
  logic [C_RT_NUM-1:0][C_IDX_W-1:0] w_rt_idx;
  logic [C_RTCNT_W-1:0]             w_rt_cnt;
  logic                             w_rollback;

  // Occupancy from registered pointers only; entries retiring this cycle
  // are not counted as free until the head has actually moved.
  always_comb begin
    w_count = r_tail - r_head;
    w_free  = C_PTR_W'(C_ROB_ENTRY_NUM) - w_count;
  end

  // Slots offered to dispatch: none during reset or a rollback cycle
  always_comb begin
    w_avail = '0;
    if (rst_i || w_rollback) begin
      w_avail = '0;
    end else if (w_free >= C_PTR_W'(C_DP_NUM)) begin
      w_avail = C_AVAIL_W'(C_DP_NUM);
    end else begin
      w_avail = C_AVAIL_W'(w_free);
    end
  end

  assign rob_avail_o = w_avail;

  // Allocate consecutive entries from the tail and count accepted slots
  always_comb begin
    dp_rob_idx_o = '0;
    w_dp_acc     = '0;
    w_dp_cnt     = '0;
    for (int k = 0; k < C_DP_NUM; k++) begin
      dp_rob_idx_o[k] = r_tail[C_IDX_W-1:0] + C_IDX_W'(k);
      if (dp_en_i[k] && (k < int'(w_avail))) begin
        w_dp_acc[k] = 1'b1;
        w_dp_cnt    = w_dp_cnt + C_AVAIL_W'(1);
      end
    end
  end

  // In-order retirement: a slot fires only if every older slot fired and no
  // older slot carried a misprediction; the mispredicted entry itself still
  // retires and publishes its register write.
  always_comb begin
    logic                v_blocked;
    logic [C_IDX_W-1:0]  v_idx;
    logic                v_comp;
    logic                v_mp;
    v_blocked  = 1'b0;
    v_idx      = '0;
    v_comp     = 1'b0;
    v_mp       = 1'b0;
    w_rt_fire  = '0;
    w_rt_idx   = '0;
    w_rt_cnt   = '0;
    w_rollback = 1'b0;
    rob_amt_o  = '0;
    for (int j = 0; j < C_RT_NUM; j++) begin
      v_idx       = r_head[C_IDX_W-1:0] + C_IDX_W'(j);
      w_rt_idx[j] = v_idx;
      v_comp      = r_complete[v_idx];
      v_mp        = r_mispred[v_idx];
`ifdef ROB_COMPLETE_BYPASS_EN
      // Same-cycle completion counts, mispredict flag included
      for (int c = 0; c < C_CDB_NUM; c++) begin
        if (cdb_valid_i[c] && r_valid[v_idx] && (cdb_rob_idx_i[c] == v_idx)) begin
          v_comp = 1'b1;
          v_mp   = cdb_mispred_i[c];
        end
      end
`endif
      if (!v_blocked && r_valid[v_idx] && v_comp) begin
        w_rt_fire[j]          = 1'b1;
        w_rt_cnt              = w_rt_cnt + C_RTCNT_W'(1);
        rob_amt_o[j].wr_en    = r_wr_en[v_idx];
        rob_amt_o[j].arch_reg = r_arch_reg[v_idx];
        rob_amt_o[j].phy_reg  = r_phy_reg[v_idx];
        if (v_mp) begin
          w_rollback = 1'b1;
          v_blocked  = 1'b1;
        end
      end else begin
        v_blocked = 1'b1;
      end
    end
  end

  assign rollback_o = w_rollback;

  // Head/tail pointer update; a rollback restarts the buffer at entry 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (w_rollback) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + C_PTR_W'(w_rt_cnt);
      r_tail <= r_tail + C_PTR_W'(w_dp_cnt);
    end
  end

  // Entry status: completion marks, retire clears, dispatch allocates.
  // Dispatch only targets free entries and retire only occupied ones, so the
  // three updates never touch the same entry in one cycle except a redundant
  // completion on a retiring entry, which the retire clear overrides.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid    <= '0;
      r_complete <= '0;
      r_mispred  <= '0;
    end else if (w_rollback) begin
      r_valid    <= '0;
      r_complete <= '0;
      r_mispred  <= '0;
    end else begin
      for (int c = 0; c < C_CDB_NUM; c++) begin
        if (cdb_valid_i[c] && r_valid[cdb_rob_idx_i[c]]) begin
          r_complete[cdb_rob_idx_i[c]] <= 1'b1;
          r_mispred[cdb_rob_idx_i[c]]  <= cdb_mispred_i[c];
        end
      end
      for (int j = 0; j < C_RT_NUM; j++) begin
        if (w_rt_fire[j]) begin
          r_valid[w_rt_idx[j]]    <= 1'b0;
          r_complete[w_rt_idx[j]] <= 1'b0;
          r_mispred[w_rt_idx[j]]  <= 1'b0;
        end
      end
      for (int k = 0; k < C_DP_NUM; k++) begin
        if (w_dp_acc[k]) begin
          r_valid[dp_rob_idx_o[k]]    <= 1'b1;
          r_complete[dp_rob_idx_o[k]] <= 1'b0;
          r_mispred[dp_rob_idx_o[k]]  <= 1'b0;
        end
      end
    end
  end

  // Entry payload written on dispatch; a write to x0 is stored as no write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_en <= '0;
      for (int i = 0; i < C_ROB_ENTRY_NUM; i++) begin
        r_arch_reg[i] <= '0;
        r_phy_reg[i]  <= '0;
      end
    end else begin
      for (int k = 0; k < C_DP_NUM; k++) begin
        if (w_dp_acc[k]) begin
          r_wr_en[dp_rob_idx_o[k]]    <= dp_wr_en_i[k] && (dp_arch_reg_i[k] != 5'd0);
          r_arch_reg[dp_rob_idx_o[k]] <= dp_arch_reg_i[k];
          r_phy_reg[dp_rob_idx_o[k]]  <= dp_phy_reg_i[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Directed testbench for rob_retire (default build, completion bypass off).
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [1:0]           dp_en;
  logic [1:0]           dp_wr_en;
  logic [1:0][4:0]      dp_arch_reg;
  logic [1:0][5:0]      dp_phy_reg;
  logic [1:0]           rob_avail;
  logic [1:0][4:0]      dp_rob_idx;
  logic [1:0]           cdb_valid;
  logic [1:0][4:0]      cdb_rob_idx;
  logic [1:0]           cdb_mispred;
  rob_amt_t [1:0]       rob_amt;
  logic                 rollback;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ret    = 0;
  logic [31:0] exp_q[$];

  rob_retire dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .dp_en_i       (dp_en),
    .dp_wr_en_i    (dp_wr_en),
    .dp_arch_reg_i (dp_arch_reg),
    .dp_phy_reg_i  (dp_phy_reg),
    .rob_avail_o   (rob_avail),
    .dp_rob_idx_o  (dp_rob_idx),
    .cdb_valid_i   (cdb_valid),
    .cdb_rob_idx_i (cdb_rob_idx),
    .cdb_mispred_i (cdb_mispred),
    .rob_amt_o     (rob_amt),
    .rollback_o    (rollback)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] amt(input logic w, input logic [4:0] a, input logic [5:0] p);
    return {20'd0, w, a, p};
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    dp_en       = '0;
    dp_wr_en    = '0;
    dp_arch_reg = '0;
    dp_phy_reg  = '0;
    cdb_valid   = '0;
    cdb_rob_idx = '0;
    cdb_mispred = '0;
  endtask

  task automatic dp2(input logic [1:0] en, input logic [1:0] we,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic [5:0] p0, input logic [5:0] p1);
    dp_en          = en;
    dp_wr_en       = we;
    dp_arch_reg[0] = a0;
    dp_arch_reg[1] = a1;
    dp_phy_reg[0]  = p0;
    dp_phy_reg[1]  = p1;
  endtask

  task automatic cdb2(input logic [1:0] v, input logic [4:0] i0, input logic [4:0] i1,
                      input logic [1:0] mp);
    cdb_valid      = v;
    cdb_rob_idx[0] = i0;
    cdb_rob_idx[1] = i1;
    cdb_mispred    = mp;
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_avail",    32'(rob_avail), 32'd0);
    check("rst_amt",      32'(rob_amt),   32'd0);
    check("rst_rollback", 32'(rollback),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_avail", 32'(rob_avail), 32'd2);

    // Two dispatches, completed together, retire together a cycle later
    dp2(2'b11, 2'b11, 5'd3, 5'd5, 6'd33, 6'd34);
    #1;
    check("t1_dp_idx0", 32'(dp_rob_idx[0]), 32'd0);
    check("t1_dp_idx1", 32'(dp_rob_idx[1]), 32'd1);
    step();
    clear_inputs();
    cdb2(2'b11, 5'd0, 5'd1, 2'b00);
    #1;
    check("t1_no_early_retire", 32'(rob_amt), 32'd0);
    step();
    clear_inputs();
    #1;
    check("t1_amt0",     32'(rob_amt[0]), amt(1'b1, 5'd3, 6'd33));
    check("t1_amt1",     32'(rob_amt[1]), amt(1'b1, 5'd5, 6'd34));
    check("t1_rollback", 32'(rollback),   32'd0);
    step();

    // A write to x0 retires with wr_en cleared
    dp2(2'b11, 2'b11, 5'd0, 5'd7, 6'd40, 6'd41);
    #1;
    check("t2_dp_idx0", 32'(dp_rob_idx[0]), 32'd2);
    step();
    clear_inputs();
    cdb2(2'b11, 5'd2, 5'd3, 2'b00);
    step();
    clear_inputs();
    #1;
    check("t2_wr_en0", 32'(rob_amt[0].wr_en), 32'd0);
    check("t2_amt0",   32'(rob_amt[0]), amt(1'b0, 5'd0, 6'd40));
    check("t2_amt1",   32'(rob_amt[1]), amt(1'b1, 5'd7, 6'd41));
    step();

    // Fill all 32 entries starting from entry 4
    for (int c = 0; c < 16; c++) begin
      dp2(2'b11, 2'b11, 5'd1, 5'd2, 6'(2 * c), 6'(2 * c + 1));
      #1;
      if (c == 0) begin
        check("fill_avail_start", 32'(rob_avail), 32'd2);
        check("fill_idx_start",   32'(dp_rob_idx[0]), 32'd4);
      end
      if (c == 13) check("fill_idx_31", 32'(dp_rob_idx[1]), 32'd31);
      if (c == 14) check("fill_idx_wrap", 32'(dp_rob_idx[0]), 32'd0);
      step();
    end
    clear_inputs();
    dp2(2'b11, 2'b11, 5'd9, 5'd9, 6'd63, 6'd63);
    cdb2(2'b01, 5'd4, 5'd0, 2'b00);
    #1;
    check("full_avail", 32'(rob_avail), 32'd0);
    step();
    clear_inputs();
    #1;
    check("full_ret0",       32'(rob_amt[0]), amt(1'b1, 5'd1, 6'd0));
    check("full_ret1",       32'(rob_amt[1]), 32'd0);
    check("full_avail_same", 32'(rob_avail),  32'd0);
    step();
    check("full_avail_after", 32'(rob_avail),     32'd1);
    check("full_tail_idx",    32'(dp_rob_idx[0]), 32'd4);

    // Asynchronous reset between edges
    rst = 1'b1;
    #1;
    check("rst_pulse_avail", 32'(rob_avail), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_pulse_avail_rel", 32'(rob_avail),     32'd2);
    check("rst_pulse_tail",      32'(dp_rob_idx[0]), 32'd0);

    // Younger entry completes first; both retire once the older completes
    dp2(2'b11, 2'b11, 5'd8, 5'd9, 6'd50, 6'd51);
    step();
    clear_inputs();
    cdb2(2'b01, 5'd1, 5'd0, 2'b00);
    #1;
    check("t4_wait_a", 32'(rob_amt), 32'd0);
    step();
    clear_inputs();
    cdb2(2'b01, 5'd0, 5'd0, 2'b00);
    #1;
    check("t4_wait_b", 32'(rob_amt), 32'd0);
    step();
    clear_inputs();
    #1;
    check("t4_amt0", 32'(rob_amt[0]), amt(1'b1, 5'd8, 6'd50));
    check("t4_amt1", 32'(rob_amt[1]), amt(1'b1, 5'd9, 6'd51));
    step();

    // Mispredicted head retires alone and flushes the buffer
    dp2(2'b11, 2'b11, 5'd10, 5'd11, 6'd60, 6'd61);
    step();
    clear_inputs();
    cdb2(2'b11, 5'd2, 5'd3, 2'b01);
    step();
    clear_inputs();
    dp2(2'b11, 2'b11, 5'd1, 5'd1, 6'd1, 6'd1);
    #1;
    check("t5_rollback", 32'(rollback),   32'd1);
    check("t5_amt0",     32'(rob_amt[0]), amt(1'b1, 5'd10, 6'd60));
    check("t5_amt1",     32'(rob_amt[1]), 32'd0);
    check("t5_avail",    32'(rob_avail),  32'd0);
    step();
    clear_inputs();
    #1;
    check("t5_post_rollback", 32'(rollback),      32'd0);
    check("t5_post_amt",      32'(rob_amt),       32'd0);
    check("t5_post_avail",    32'(rob_avail),     32'd2);
    check("t5_post_idx0",     32'(dp_rob_idx[0]), 32'd0);
    check("t5_post_idx1",     32'(dp_rob_idx[1]), 32'd1);

    // 40 single dispatch/complete/retire pairs through the pointer wrap
    for (int i = 0; i < 44; i++) begin
      clear_inputs();
      if (i < 40) begin
        dp2(2'b01, 2'b01, 5'(i % 31 + 1), 5'd0, 6'(i), 6'd0);
        exp_q.push_back(amt(1'b1, 5'(i % 31 + 1), 6'(i)));
      end
      if (i >= 1 && i <= 40) cdb2(2'b01, 5'((i - 1) % 32), 5'd0, 2'b00);
      #1;
      if (i < 40) check("stream_avail", 32'(rob_avail), 32'd2);
      if (i == 31) check("stream_idx_31", 32'(dp_rob_idx[0]), 32'd31);
      if (i == 32) check("stream_idx_0",  32'(dp_rob_idx[0]), 32'd0);
      for (int j = 0; j < 2; j++) begin
        if (32'(rob_amt[j]) != 32'd0) begin
          if (exp_q.size() == 0) begin
            check("stream_unexpected", 32'(rob_amt[j]), 32'd0);
          end else begin
            check("stream_retire", 32'(rob_amt[j]), exp_q.pop_front());
            n_ret++;
          end
        end
      end
      step();
    end
    check("stream_count",   32'(n_ret),        32'd40);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a retiring cycle clears outputs immediately
    clear_inputs();
    dp2(2'b11, 2'b11, 5'd12, 5'd13, 6'd20, 6'd21);
    #1;
    check("rm_dp_idx0", 32'(dp_rob_idx[0]), 32'd8);
    step();
    clear_inputs();
    cdb2(2'b11, 5'd8, 5'd9, 2'b00);
    step();
    clear_inputs();
    #1;
    check("rm_amt0_pre", 32'(rob_amt[0]), amt(1'b1, 5'd12, 6'd20));
    rst = 1'b1;
    #1;
    check("rm_amt_async",  32'(rob_amt),   32'd0);
    check("rm_rollback",   32'(rollback),  32'd0);
    check("rm_avail",      32'(rob_avail), 32'd0);
    rst = 1'b0;
    #1;
    check("rm_tail_idx",   32'(dp_rob_idx[0]), 32'd0);
    check("rm_avail_rel",  32'(rob_avail),     32'd2);
    step();
    check("rm_amt_after",  32'(rob_amt), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
